// File: rtl/tinyqv_serial_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tinyqv_serial_regfile
// Brief    : Slice-serial RISC-V register file. One SLICE_BITS-wide slice of
//            every register is presented per phase; x0/x3/x4 may be constants.
// Revision : 1.0 - initial release
// ============================================================================
module tinyqv_serial_regfile #(
  parameter int          NUM_REGS       = 16,
  parameter int          REG_ADDR_BITS  = 4,
  parameter int          SLICE_BITS     = 4,
  parameter bit          HARDWIRE_GP_TP = 1'b1,
  parameter logic [31:0] GP_VALUE       = 32'h00001000,
  parameter logic [31:0] TP_VALUE       = 32'h10000000,
  localparam int         STEPS          = 32 / SLICE_BITS,
  localparam int         PHASE_BITS     = $clog2(STEPS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     advance,
  input  logic                     wr_en,
  input  logic [REG_ADDR_BITS-1:0] rs1,
  input  logic [REG_ADDR_BITS-1:0] rs2,
  input  logic [REG_ADDR_BITS-1:0] rd,
  input  logic [SLICE_BITS-1:0]    data_rd,
  output logic [SLICE_BITS-1:0]    data_rs1,
  output logic [SLICE_BITS-1:0]    data_rs2,
  output logic [PHASE_BITS-1:0]    phase,
  output logic                     last
);

  localparam int OFF_BITS = 5;

  logic [PHASE_BITS-1:0] r_phase;
  logic [PHASE_BITS-1:0] w_wr_phase;
  logic [OFF_BITS-1:0]   w_rd_off;
  logic [OFF_BITS-1:0]   w_wr_off;
  logic                  w_write;
  logic [31:0]           w_reg_val [NUM_REGS];
  logic [31:0]           w_rs1_word;
  logic [31:0]           w_rs2_word;

  // STEPS is a power of two, so natural counter overflow gives the wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= '0;
    end else if (advance) begin
      r_phase <= r_phase + PHASE_BITS'(1);
    end
  end

  // Writes land one slice behind the read phase: the write slice was read last cycle.
  assign w_wr_phase = r_phase - PHASE_BITS'(1);
  assign w_rd_off   = OFF_BITS'(r_phase) * OFF_BITS'(SLICE_BITS);
  assign w_wr_off   = OFF_BITS'(w_wr_phase) * OFF_BITS'(SLICE_BITS);
  assign w_write    = advance & wr_en;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign w_reg_val[gi] = '0;
    end else if (HARDWIRE_GP_TP && gi == 3) begin : g_gp
      assign w_reg_val[gi] = GP_VALUE;
    end else if (HARDWIRE_GP_TP && gi == 4) begin : g_tp
      assign w_reg_val[gi] = TP_VALUE;
    end else begin : g_store
      logic [31:0] r_val;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_val <= '0;
        end else if (w_write && rd == REG_ADDR_BITS'(gi)) begin
          r_val[w_wr_off +: SLICE_BITS] <= data_rd;
        end
      end

      assign w_reg_val[gi] = r_val;
    end
  end

  // Indices with no matching register fall through to zero.
  always_comb begin
    w_rs1_word = '0;
    w_rs2_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs1 == REG_ADDR_BITS'(i)) begin
        w_rs1_word = w_reg_val[i];
      end
      if (rs2 == REG_ADDR_BITS'(i)) begin
        w_rs2_word = w_reg_val[i];
      end
    end
  end

  assign data_rs1 = SLICE_BITS'(w_rs1_word >> w_rd_off);
  assign data_rs2 = SLICE_BITS'(w_rs2_word >> w_rd_off);
  assign phase    = r_phase;
  assign last     = (r_phase == PHASE_BITS'(STEPS - 1));

endmodule
`default_nettype wire
